// File: rtl/noc_bridge_nch_if.sv
// -----------------------------------------------------------------------------
// noc_bridge_nch_if
// Bundles the inbound flit port and the NUM_CH outbound virtual-channel ports
// of the NoC channel bridge.
//   Noc_receive_*  : single inbound flit stream (valid/ready, flit, header/tail)
//   Noc_sender_*   : per-channel outbound streams; flit of channel c lives in
//                    Noc_sender_flit[c*DATA_WIDTH +: DATA_WIDTH]
// Modports:
//   master : the environment (upstream node and downstream fabric ports)
//   slave  : the bridge itself
// -----------------------------------------------------------------------------
interface noc_bridge_nch_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 4
);
    logic                         Noc_receive_valid;
    logic                         Noc_receive_ready;
    logic [DATA_WIDTH-1:0]        Noc_receive_flit;
    logic                         Noc_receive_is_header;
    logic                         Noc_receive_is_tail;

    logic [NUM_CH-1:0]            Noc_sender_valid;
    logic [NUM_CH-1:0]            Noc_sender_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] Noc_sender_flit;
    logic [NUM_CH-1:0]            Noc_sender_VCready;
    logic [NUM_CH-1:0]            Noc_sender_is_header;
    logic [NUM_CH-1:0]            Noc_sender_is_tail;

    modport master (
        output Noc_receive_valid,
        input  Noc_receive_ready,
        output Noc_receive_flit,
        output Noc_receive_is_header,
        output Noc_receive_is_tail,
        input  Noc_sender_valid,
        output Noc_sender_ready,
        input  Noc_sender_flit,
        output Noc_sender_VCready,
        input  Noc_sender_is_header,
        input  Noc_sender_is_tail
    );

    modport slave (
        input  Noc_receive_valid,
        output Noc_receive_ready,
        input  Noc_receive_flit,
        input  Noc_receive_is_header,
        input  Noc_receive_is_tail,
        output Noc_sender_valid,
        input  Noc_sender_ready,
        output Noc_sender_flit,
        input  Noc_sender_VCready,
        output Noc_sender_is_header,
        output Noc_sender_is_tail
    );
endinterface

// File: rtl/noc_bridge_nch.sv
// -----------------------------------------------------------------------------
// noc_bridge_nch
// Splits one inbound flit stream into NUM_CH outbound virtual-channel streams.
// Packets are kept atomic: the header picks a channel (from a header field or
// per-packet round-robin) and every flit up to the tail follows it. Each
// channel owns a first-word-fall-through FIFO whose valid is gated by the
// downstream VCready.
// Ports:
//   noc_clk, noc_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : inbound and per-channel outbound flit ports
//   drop_cnt           : packets dropped for an out-of-range channel id,
//                        saturating at 16'hFFFF
//   err_orphan         : sticky, a body/tail flit arrived with no open packet
// -----------------------------------------------------------------------------
module noc_bridge_nch #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_SEL_LSB = 0,
    parameter int SEL_MODE   = 0
) (
    input  logic                 noc_clk,
    input  logic                 noc_rst_n,
    noc_bridge_nch_if.slave      bus,
    output logic [15:0]          drop_cnt,
    output logic                 err_orphan
);

    localparam int SEL_W = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_WIDTH + 2;

    // Channel id widened by one bit so ids >= NUM_CH are detectable when
    // NUM_CH is not a power of two.
    localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SEL_W-1:0]   cur_ch_r;
    logic [SEL_W-1:0]   cur_ch_nxt_s;
    logic [SEL_W-1:0]   rr_ptr_r;

    logic [ENT_W-1:0]   mem_r    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r [NUM_CH];
    logic [PTR_W-1:0]   rd_ptr_r [NUM_CH];
    logic [CNT_W-1:0]   count_r  [NUM_CH];

    logic [NUM_CH-1:0]  full_s;
    logic [NUM_CH-1:0]  empty_s;
    logic [NUM_CH-1:0]  push_s;
    logic [NUM_CH-1:0]  pop_s;

    logic [NUM_CH-1:0]            valid_s;
    logic [NUM_CH-1:0]            hdr_s;
    logic [NUM_CH-1:0]            tail_s;
    logic [NUM_CH*DATA_WIDTH-1:0] flit_s;

    logic [SEL_W-1:0]   sel_s;
    logic               sel_ok_s;
    logic               rx_ready_s;
    logic               rx_fire_s;
    logic               push_en_s;
    logic [SEL_W-1:0]   push_ch_s;
    logic               rr_adv_s;
    logic               drop_inc_s;
    logic               orphan_set_s;
    logic [ENT_W-1:0]   rx_entry_s;

    assign rx_entry_s = {bus.Noc_receive_is_header, bus.Noc_receive_is_tail,
                         bus.Noc_receive_flit};

    // Candidate channel for a header seen in IDLE and its range check.
    always_comb begin
        if (SEL_MODE == 1) begin
            sel_s = rr_ptr_r;
        end else begin
            sel_s = bus.Noc_receive_flit[CH_SEL_LSB +: SEL_W];
        end
        sel_ok_s = ({1'b0, sel_s} < NUM_CH_EXT);
    end

    // Per-channel FIFO status, push/pop strobes and head-of-FIFO outputs.
    always_comb begin
        full_s  = '0;
        empty_s = '0;
        push_s  = '0;
        pop_s   = '0;
        valid_s = '0;
        hdr_s   = '0;
        tail_s  = '0;
        flit_s  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full_s[c]  = (count_r[c] == DEPTH_CNT);
            empty_s[c] = (count_r[c] == {CNT_W{1'b0}});
            push_s[c]  = push_en_s && (push_ch_s == SEL_W'(c));
            valid_s[c] = !empty_s[c] && bus.Noc_sender_VCready[c];
            pop_s[c]   = valid_s[c] && bus.Noc_sender_ready[c];
            // Head is masked while empty so idle channels present all-zero.
            if (!empty_s[c]) begin
                hdr_s[c]  = mem_r[c][rd_ptr_r[c]][ENT_W-1];
                tail_s[c] = mem_r[c][rd_ptr_r[c]][ENT_W-2];
                flit_s[c*DATA_WIDTH +: DATA_WIDTH] =
                    mem_r[c][rd_ptr_r[c]][DATA_WIDTH-1:0];
            end else begin
                hdr_s[c]  = 1'b0;
                tail_s[c] = 1'b0;
            end
        end
    end

    assign bus.Noc_sender_valid     = valid_s;
    assign bus.Noc_sender_is_header = hdr_s;
    assign bus.Noc_sender_is_tail   = tail_s;
    assign bus.Noc_sender_flit      = flit_s;
    assign bus.Noc_receive_ready    = rx_ready_s;

    // Packet FSM: next state, inbound ready and push/drop/orphan decisions.
    // Ready looks only at the full flag, so a same-cycle pop never opens room.
    always_comb begin
        state_nxt_s  = state_r;
        cur_ch_nxt_s = cur_ch_r;
        rx_ready_s   = 1'b1;
        rx_fire_s    = 1'b0;
        push_en_s    = 1'b0;
        push_ch_s    = cur_ch_r;
        rr_adv_s     = 1'b0;
        drop_inc_s   = 1'b0;
        orphan_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.Noc_receive_is_header && sel_ok_s) begin
                    rx_ready_s = !full_s[sel_s];
                    rx_fire_s  = bus.Noc_receive_valid && rx_ready_s;
                    if (rx_fire_s) begin
                        push_en_s    = 1'b1;
                        push_ch_s    = sel_s;
                        cur_ch_nxt_s = sel_s;
                        rr_adv_s     = (SEL_MODE == 1);
                        state_nxt_s  = bus.Noc_receive_is_tail ? ST_IDLE : ST_FWD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (bus.Noc_receive_is_header) begin
                    // Channel id out of range: swallow the whole packet.
                    rx_ready_s = 1'b1;
                    rx_fire_s  = bus.Noc_receive_valid;
                    if (rx_fire_s) begin
                        drop_inc_s  = 1'b1;
                        state_nxt_s = bus.Noc_receive_is_tail ? ST_IDLE : ST_DROP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    // Body/tail with no open packet: discard and flag.
                    rx_ready_s = 1'b1;
                    rx_fire_s  = bus.Noc_receive_valid;
                    if (rx_fire_s) begin
                        orphan_set_s = 1'b1;
                    end else begin
                        orphan_set_s = 1'b0;
                    end
                end
            end
            ST_FWD: begin
                // A header arriving here is just another flit of the packet.
                rx_ready_s = !full_s[cur_ch_r];
                rx_fire_s  = bus.Noc_receive_valid && rx_ready_s;
                if (rx_fire_s) begin
                    push_en_s = 1'b1;
                    if (bus.Noc_receive_is_tail) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FWD;
                    end
                end else begin
                    state_nxt_s = ST_FWD;
                end
            end
            ST_DROP: begin
                rx_ready_s = 1'b1;
                rx_fire_s  = bus.Noc_receive_valid;
                if (rx_fire_s && bus.Noc_receive_is_tail) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, bound channel, round-robin pointer and status registers.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_r    <= ST_IDLE;
            cur_ch_r   <= {SEL_W{1'b0}};
            rr_ptr_r   <= {SEL_W{1'b0}};
            drop_cnt   <= 16'h0000;
            err_orphan <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cur_ch_r <= cur_ch_nxt_s;
            if (rr_adv_s) begin
                rr_ptr_r <= (rr_ptr_r == LAST_CH) ? {SEL_W{1'b0}}
                                                  : rr_ptr_r + SEL_W'(1);
            end
            if (drop_inc_s && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'h0001;
            end
            if (orphan_set_s) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; push+pop together keeps occupancy.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_r[c] <= {PTR_W{1'b0}};
                rd_ptr_r[c] <= {PTR_W{1'b0}};
                count_r[c]  <= {CNT_W{1'b0}};
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push_s[c]) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + PTR_W'(1);
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + PTR_W'(1);
                end
                case ({push_s[c], pop_s[c]})
                    2'b10:   count_r[c] <= count_r[c] + CNT_W'(1);
                    2'b01:   count_r[c] <= count_r[c] - CNT_W'(1);
                    default: count_r[c] <= count_r[c];
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care while the entry is not occupied.
    always_ff @(posedge noc_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= rx_entry_s;
            end
        end
    end

endmodule

// File: tb/tb_noc_bridge_nch.sv
// -----------------------------------------------------------------------------
// tb_noc_bridge_nch
// Directed bench for noc_bridge_nch. Three instances share one inbound driver:
//   u_dut0 : NUM_CH=4, header-field selection
//   u_dut1 : NUM_CH=3, header-field selection (out-of-range id -> drop)
//   u_dut2 : NUM_CH=4, per-packet round-robin
// The variable tgt picks which instance sees rx_valid.
// -----------------------------------------------------------------------------
module tb_noc_bridge_nch;

    localparam int DW = 64;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [63:0] rx_flit;
    logic        rx_hdr;
    logic        rx_tail;
    int          tgt;
    logic        rx_ready;

    logic [3:0]  s_rdy0, vc0, s_rdy2, vc2;
    logic [2:0]  s_rdy1, vc1;
    logic [15:0] drop0, drop1, drop2;
    logic        err0, err1, err2;

    int checks = 0;
    int errors = 0;

    noc_bridge_nch_if #(.DATA_WIDTH(DW), .NUM_CH(4)) if0 ();
    noc_bridge_nch_if #(.DATA_WIDTH(DW), .NUM_CH(3)) if1 ();
    noc_bridge_nch_if #(.DATA_WIDTH(DW), .NUM_CH(4)) if2 ();

    assign if0.Noc_receive_valid     = rx_valid && (tgt == 0);
    assign if0.Noc_receive_flit      = rx_flit;
    assign if0.Noc_receive_is_header = rx_hdr;
    assign if0.Noc_receive_is_tail   = rx_tail;
    assign if0.Noc_sender_ready      = s_rdy0;
    assign if0.Noc_sender_VCready    = vc0;

    assign if1.Noc_receive_valid     = rx_valid && (tgt == 1);
    assign if1.Noc_receive_flit      = rx_flit;
    assign if1.Noc_receive_is_header = rx_hdr;
    assign if1.Noc_receive_is_tail   = rx_tail;
    assign if1.Noc_sender_ready      = s_rdy1;
    assign if1.Noc_sender_VCready    = vc1;

    assign if2.Noc_receive_valid     = rx_valid && (tgt == 2);
    assign if2.Noc_receive_flit      = rx_flit;
    assign if2.Noc_receive_is_header = rx_hdr;
    assign if2.Noc_receive_is_tail   = rx_tail;
    assign if2.Noc_sender_ready      = s_rdy2;
    assign if2.Noc_sender_VCready    = vc2;

    assign rx_ready = (tgt == 0) ? if0.Noc_receive_ready :
                      (tgt == 1) ? if1.Noc_receive_ready : if2.Noc_receive_ready;

    noc_bridge_nch #(.DATA_WIDTH(DW), .NUM_CH(4), .FIFO_DEPTH(4),
                     .CH_SEL_LSB(0), .SEL_MODE(0)) u_dut0 (
        .noc_clk(clk), .noc_rst_n(rst_n), .bus(if0.slave),
        .drop_cnt(drop0), .err_orphan(err0));

    noc_bridge_nch #(.DATA_WIDTH(DW), .NUM_CH(3), .FIFO_DEPTH(4),
                     .CH_SEL_LSB(0), .SEL_MODE(0)) u_dut1 (
        .noc_clk(clk), .noc_rst_n(rst_n), .bus(if1.slave),
        .drop_cnt(drop1), .err_orphan(err1));

    noc_bridge_nch #(.DATA_WIDTH(DW), .NUM_CH(4), .FIFO_DEPTH(4),
                     .CH_SEL_LSB(0), .SEL_MODE(1)) u_dut2 (
        .noc_clk(clk), .noc_rst_n(rst_n), .bus(if2.slave),
        .drop_cnt(drop2), .err_orphan(err2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Offers one flit for up to maxc cycles; acc tells whether it was taken.
    // Called just after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [63:0] f, input logic h, input logic t,
                        input int maxc, output logic acc);
        logic r;
        acc      = 1'b0;
        rx_flit  = f;
        rx_hdr   = h;
        rx_tail  = t;
        rx_valid = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_ok(input string tag, input logic [63:0] f,
                           input logic h, input logic t);
        logic acc;
        send(f, h, t, 40, acc);
        check(tag, {63'd0, acc}, 64'd1);
    endtask

    initial begin
        logic        acc;
        logic        seen;
        int          n;
        logic [63:0] exp_q [5];

        rst_n = 1'b0; rx_valid = 1'b0; rx_flit = 64'd0; rx_hdr = 1'b0;
        rx_tail = 1'b0; tgt = 0;
        s_rdy0 = 4'h0; vc0 = 4'hF; s_rdy1 = 3'h0; vc1 = 3'h7;
        s_rdy2 = 4'h0; vc2 = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_valid0", {60'd0, if0.Noc_sender_valid}, 64'd0);
        check("rst_valid1", {61'd0, if1.Noc_sender_valid}, 64'd0);
        check("rst_drop1",  {48'd0, drop1}, 64'd0);
        check("rst_err0",   {63'd0, err0}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-flit packet to channel 2.
        tgt = 0;
        send_ok("t1_acc", 64'hCAFE_0000_0000_0002, 1'b1, 1'b1);
        @(negedge clk);
        check("t1_valid", {60'd0, if0.Noc_sender_valid}, 64'h4);
        check("t1_flit",  if0.Noc_sender_flit[2*DW +: DW], 64'hCAFE_0000_0000_0002);
        check("t1_hdr",   {60'd0, if0.Noc_sender_is_header}, 64'h4);
        check("t1_tail",  {60'd0, if0.Noc_sender_is_tail}, 64'h4);
        s_rdy0 = 4'hF;
        @(negedge clk);
        check("t1_drained", {60'd0, if0.Noc_sender_valid}, 64'd0);
        @(posedge clk); #1;

        // 5-flit packet to channel 1 with the channel stalled.
        s_rdy0 = 4'h0;
        for (int i = 0; i < 5; i++) exp_q[i] = 64'h0000_0000_0000_1001 + 64'(i);
        send_ok("t2_acc0", exp_q[0], 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) send_ok("t2_acc", exp_q[i], 1'b0, 1'b0);
        @(negedge clk);
        check("t2_ready_full", {63'd0, rx_ready}, 64'd0);
        check("t2_valid", {60'd0, if0.Noc_sender_valid}, 64'h2);
        @(posedge clk); #1;
        n = 0;
        seen = 1'b0;
        fork
            send_ok("t2_acc4", exp_q[4], 1'b0, 1'b1);
            begin
                s_rdy0 = 4'b0010;
                for (int cyc = 0; cyc < 30 && n < 5; cyc++) begin
                    @(negedge clk);
                    seen = seen | if0.Noc_sender_valid[0];
                    if (if0.Noc_sender_valid[1]) begin
                        check("t2_flit", if0.Noc_sender_flit[DW +: DW], exp_q[n]);
                        check("t2_hdr",  {63'd0, if0.Noc_sender_is_header[1]},
                              (n == 0) ? 64'd1 : 64'd0);
                        check("t2_tail", {63'd0, if0.Noc_sender_is_tail[1]},
                              (n == 4) ? 64'd1 : 64'd0);
                        n++;
                    end
                end
            end
        join
        check("t2_count", 64'(n), 64'd5);
        check("t2_ch0_idle", {63'd0, seen}, 64'd0);
        s_rdy0 = 4'hF;
        @(posedge clk); #1;

        // Channel 3 held off by VCready for 10 cycles.
        vc0 = 4'b0111;
        send_ok("t3_acc", 64'h0000_0000_0000_3003, 1'b1, 1'b1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | if0.Noc_sender_valid[3];
        end
        check("t3_hold", {63'd0, seen}, 64'd0);
        vc0 = 4'hF;
        #1;
        check("t3_valid", {60'd0, if0.Noc_sender_valid}, 64'h8);
        check("t3_flit",  if0.Noc_sender_flit[3*DW +: DW], 64'h0000_0000_0000_3003);
        @(negedge clk);
        check("t3_drained", {60'd0, if0.Noc_sender_valid}, 64'd0);
        @(posedge clk); #1;

        // NUM_CH=3: header id 3 is out of range, whole packet dropped.
        tgt = 1;
        s_rdy1 = 3'h0;
        send(64'h0000_0000_0000_0003, 1'b1, 1'b0, 1, acc);
        check("t4_rdy_h", {63'd0, acc}, 64'd1);
        send(64'h0000_0000_0000_DEAD, 1'b0, 1'b0, 1, acc);
        check("t4_rdy_b", {63'd0, acc}, 64'd1);
        send(64'h0000_0000_0000_BEEF, 1'b0, 1'b1, 1, acc);
        check("t4_rdy_t", {63'd0, acc}, 64'd1);
        @(negedge clk);
        check("t4_drop", {48'd0, drop1}, 64'd1);
        check("t4_valid_none", {61'd0, if1.Noc_sender_valid}, 64'd0);
        check("t4_no_orphan", {63'd0, err1}, 64'd0);
        @(posedge clk); #1;
        send_ok("t4_acc_h", 64'h0000_0000_0000_7702, 1'b1, 1'b0);
        send_ok("t4_acc_t", 64'h0000_0000_0000_7703, 1'b0, 1'b1);
        @(negedge clk);
        check("t4_route", {61'd0, if1.Noc_sender_valid}, 64'h4);
        check("t4_flit", if1.Noc_sender_flit[2*DW +: DW], 64'h0000_0000_0000_7702);
        s_rdy1 = 3'h7;
        repeat (2) @(negedge clk);
        check("t4_drained", {61'd0, if1.Noc_sender_valid}, 64'd0);
        @(posedge clk); #1;

        // Round-robin mode: header field bits deliberately disagree with rr.
        tgt = 2;
        for (int k = 0; k < 4; k++) begin
            send_ok("t5_acc_h", 64'h0000_0000_0000_A000 | 64'(3 - k), 1'b1, 1'b0);
            send_ok("t5_acc_t", 64'h0000_0000_0000_B000 + 64'(k), 1'b0, 1'b1);
        end
        @(negedge clk);
        check("t5_valid", {60'd0, if2.Noc_sender_valid}, 64'hF);
        for (int k = 0; k < 4; k++) begin
            check("t5_head", if2.Noc_sender_flit[k*DW +: DW],
                  64'h0000_0000_0000_A000 | 64'(3 - k));
        end
        @(posedge clk); #1;
        send_ok("t5_acc_h5", 64'h0000_0000_0000_A103, 1'b1, 1'b0);
        send_ok("t5_acc_t5", 64'h0000_0000_0000_B104, 1'b0, 1'b1);
        exp_q[0] = 64'h0000_0000_0000_A003;
        exp_q[1] = 64'h0000_0000_0000_B000;
        exp_q[2] = 64'h0000_0000_0000_A103;
        exp_q[3] = 64'h0000_0000_0000_B104;
        n = 0;
        s_rdy2 = 4'b0001;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            @(negedge clk);
            if (if2.Noc_sender_valid[0]) begin
                check("t5_ch0", if2.Noc_sender_flit[DW-1:0], exp_q[n]);
                n++;
            end
        end
        check("t5_ch0_count", 64'(n), 64'd4);
        s_rdy2 = 4'hF;
        @(posedge clk); #1;

        // Orphan body flit while idle.
        tgt = 0;
        send_ok("t6_acc", 64'h0000_0000_0000_0055, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_err", {63'd0, err0}, 64'd1);
        check("t6_valid", {60'd0, if0.Noc_sender_valid}, 64'd0);
        @(posedge clk); #1;

        // Reset mid-packet, then a fresh header must route normally.
        s_rdy0 = 4'h0;
        send_ok("t7_acc_h", 64'h0000_0000_0000_0001, 1'b1, 1'b0);
        send_ok("t7_acc_b", 64'h0000_0000_0000_0BAD, 1'b0, 1'b0);
        @(negedge clk);
        check("t7_pre", {60'd0, if0.Noc_sender_valid}, 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", {60'd0, if0.Noc_sender_valid}, 64'd0);
        check("t7_rst_drop1", {48'd0, drop1}, 64'd0);
        check("t7_rst_err", {63'd0, err0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_ok("t7_acc_new", 64'h0000_0000_0000_0002, 1'b1, 1'b1);
        @(negedge clk);
        check("t7_route", {60'd0, if0.Noc_sender_valid}, 64'h4);
        check("t7_flit", if0.Noc_sender_flit[2*DW +: DW], 64'h0000_0000_0000_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
